// File: rtl/instruction_fetch_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states, buffer entry
// layout and the sequential PC step.
package instruction_fetch_pkg;

    localparam int unsigned PC_STEP  = 4;
    localparam int unsigned DEF_IBUS = 32;
    localparam int unsigned DEF_MBUS = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_IBUS-1:0] instruction;
        logic [DEF_MBUS-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_buffer.sv
// Two-entry synchronous FIFO holding fetched {instruction, pc} pairs.
// The entry type is a parameter so the top can size it to its bus widths.
module fetch_buffer
    import instruction_fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
)
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_push,
    input  entry_t i_data,
    input  logic   i_pop,
    input  logic   i_flush,
    output entry_t o_head,
    output logic   o_full,
    output logic   o_empty
);

    entry_t     r_mem [2];
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic w_do_pop;
    logic w_do_push;
    logic w_wr_ptr;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);
    assign w_wr_ptr  = r_rd_ptr ^ r_count[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[w_wr_ptr] <= i_data;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory requests into a 2-entry buffer
// feeding decode. Optional perf counters under FETCH_PERF_EN.
//
// state   | meaning
// IDLE    | nothing outstanding
// WAIT    | request outstanding, response will be buffered
// DISCARD | request outstanding, response is stale (redirected) and dropped
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int              ibus     = 32,
    parameter int              mbus     = 32,
    parameter logic [mbus-1:0] RESET_PC = '0
)
(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [mbus-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ibus-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [mbus-1:0] redirect_pc,
    input  logic            dec_ready,
    output logic            dec_valid,
    output logic [ibus-1:0] instruction,
    output logic [mbus-1:0] pcDir
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);

    typedef struct packed {
        logic [ibus-1:0] instruction;
        logic [mbus-1:0] pc;
    } if_entry_t;

    fetch_state_t    r_state;
    logic            r_req;
    logic [mbus-1:0] r_addr;
    logic [mbus-1:0] r_pc;

    if_entry_t       w_head;
    if_entry_t       w_push_data;
    logic            w_full;
    logic            w_empty;
    logic            w_ack;
    logic            w_push;
    logic            w_pop;
    logic            w_busy_next;
    logic            w_issue;
    logic [1:0]      w_count;
    logic [1:0]      w_count_next;
    logic [mbus-1:0] w_pc_next;
    logic            w_unused;

    assign w_unused = ^redirect_pc[1:0];

    assign w_ack   = r_req && imem_ack;
    assign w_push  = w_ack && (r_state == WAIT) && !redirect;
    assign w_pop   = !w_empty && dec_ready && !redirect;
    assign w_count = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);

    assign w_push_data.instruction = imem_rdata;
    assign w_push_data.pc          = r_addr;

    always_comb begin
        w_pc_next = r_pc;
        if (redirect) begin
            w_pc_next = {redirect_pc[mbus-1:2], 2'b00};
        end else if (w_push) begin
            w_pc_next = r_pc + mbus'(PC_STEP);
        end
    end

    always_comb begin
        w_count_next = w_count;
        if (redirect) begin
            w_count_next = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = w_count + 2'd1;
                2'b01:   w_count_next = w_count - 2'd1;
                default: w_count_next = w_count;
            endcase
        end
    end

    // A new request may launch on the same edge that retires the previous one.
    assign w_busy_next = (r_state != IDLE) && !w_ack;
    assign w_issue     = !w_busy_next && (w_count_next < 2'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_pc    <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state <= WAIT;
                        r_req   <= 1'b1;
                        r_addr  <= w_pc_next;
                    end
                end
                WAIT, DISCARD: begin
                    if (w_ack) begin
                        if (w_issue) begin
                            r_state <= WAIT;
                            r_addr  <= w_pc_next;
                        end else begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                        end
                    end else if (redirect) begin
                        r_state <= DISCARD;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    fetch_buffer #(
        .entry_t (if_entry_t)
    ) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign dec_valid   = !w_empty;
    assign instruction = w_empty ? '0 : w_head.instruction;
    assign pcDir       = w_empty ? '0 : w_head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_push) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (dec_valid && !dec_ready) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule
